// File: rtl/axi_checker_sequencer_if.sv
// axi_checker_sequencer_if: control/status bundle between the campaign sequencer and its checker bank.
// Signals: start, stop, loop_count, chk_mask (campaign control); chk_wr_en, chk_rd_en (per-checker enables);
// chk_wr_finish, chk_rd_finish, chk_fail (per-checker responses); busy, seq_done, pass, error,
// timeout_err, fail_vec, active_idx, loops_done (campaign status).
// master: sequencer side. slave: environment/checker side.
interface axi_checker_sequencer_if #(
  parameter int NUM_CHK = 4,
  parameter int LOOP_W  = 16,
  parameter int IDX_W   = $clog2(NUM_CHK)
);
  logic               start;
  logic               stop;
  logic [LOOP_W-1:0]  loop_count;
  logic [NUM_CHK-1:0] chk_mask;
  logic [NUM_CHK-1:0] chk_wr_en;
  logic [NUM_CHK-1:0] chk_rd_en;
  logic [NUM_CHK-1:0] chk_wr_finish;
  logic [NUM_CHK-1:0] chk_rd_finish;
  logic [NUM_CHK-1:0] chk_fail;
  logic               busy;
  logic               seq_done;
  logic               pass;
  logic               error;
  logic               timeout_err;
  logic [NUM_CHK-1:0] fail_vec;
  logic [IDX_W-1:0]   active_idx;
  logic [LOOP_W-1:0]  loops_done;
  modport master (
    input  start, stop, loop_count, chk_mask, chk_wr_finish, chk_rd_finish, chk_fail,
    output chk_wr_en, chk_rd_en, busy, seq_done, pass, error, timeout_err, fail_vec, active_idx, loops_done
  );
  modport slave (
    output start, stop, loop_count, chk_mask, chk_wr_finish, chk_rd_finish, chk_fail,
    input  chk_wr_en, chk_rd_en, busy, seq_done, pass, error, timeout_err, fail_vec, active_idx, loops_done
  );
endinterface

// File: rtl/axi_checker_sequencer.sv
// axi_checker_sequencer: round-robin write/read-back campaign controller for a bank of AXI checkers.
// Ports: clk, rst (async, active-high); bus (axi_checker_sequencer_if.master) carries campaign
// control in, one-hot checker enables out, checker finish/fail pulses in, and sticky status out.
// Optional watchdog: define CHK_SEQ_WATCHDOG_EN to abort a phase after TIMEOUT_CYC cycles.
module axi_checker_sequencer #(
  parameter int NUM_CHK     = 4,
  parameter int LOOP_W      = 16,
  parameter int TIMEOUT_CYC = 1048576,
  localparam int IDX_W      = $clog2(NUM_CHK)
) (
  input logic                     clk,
  input logic                     rst,
  axi_checker_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, NEXT, END, ERR} state_t;
  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_CHK-1:0] mask_q, mask_d;
  logic [LOOP_W-1:0]  lc_q, lc_d;
  logic [LOOP_W-1:0]  loops_q, loops_d;
  logic               pass_q, pass_d;
  logic               error_q, error_d;
  logic               tmo_q, tmo_d;
  logic [NUM_CHK-1:0] fvec_q, fvec_d;
  logic               done_q, done_d;
  logic [NUM_CHK-1:0] en_q, en_d;
  logic [IDX_W-1:0]   low_mask, low_start, up;
  logic               has_up;
  logic               active;
  logic               fail_hit;
  logic               stop_hit;
  logic               timeout;
  logic [LOOP_W-1:0]  loops_inc;
  assign active    = state_q == WRITE || state_q == READ || state_q == NEXT;
  assign fail_hit  = active && |(bus.chk_fail & mask_q);
  assign stop_hit  = active && bus.stop;
  assign loops_inc = &loops_q ? loops_q : loops_q + 1'b1;
`ifdef CHK_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            in_phase;
  assign in_phase = state_q == WRITE || state_q == READ;
  assign timeout  = in_phase && wd_q == WD_W'(TIMEOUT_CYC - 1);
  // Any state change restarts the count, so every WRITE/READ entry begins at zero.
  assign wd_d     = state_d != state_q ? '0 : in_phase ? wd_q + 1'b1 : wd_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) wd_q <= '0;
    else wd_q <= wd_d;
`else
  assign timeout = 1'b0 && TIMEOUT_CYC > 0;
`endif
  // Descending scan: the last hit written is the lowest qualifying index.
  always_comb begin
    low_mask  = '0;
    low_start = '0;
    up        = '0;
    has_up    = 1'b0;
    for (int i = NUM_CHK - 1; i >= 0; i--) begin
      if (mask_q[i]) low_mask = IDX_W'(i);
      if (bus.chk_mask[i]) low_start = IDX_W'(i);
      if (mask_q[i] && i > int'(idx_q)) begin
        up     = IDX_W'(i);
        has_up = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    lc_d    = lc_q;
    loops_d = loops_q;
    pass_d  = pass_q;
    error_d = error_q;
    tmo_d   = tmo_q;
    fvec_d  = fvec_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE:
        if (bus.start && |bus.chk_mask) begin
          state_d = WRITE;
          mask_d  = bus.chk_mask;
          lc_d    = bus.loop_count;
          idx_d   = low_start;
          pass_d  = 1'b0;
          error_d = 1'b0;
          tmo_d   = 1'b0;
          fvec_d  = '0;
          loops_d = '0;
        end
      WRITE: state_d = bus.chk_wr_finish[idx_q] ? READ : WRITE;
      READ:  state_d = bus.chk_rd_finish[idx_q] ? NEXT : READ;
      NEXT: begin
        idx_d   = has_up ? up : low_mask;
        loops_d = has_up ? loops_q : loops_inc;
        if (!has_up && lc_q != '0 && loops_inc == lc_q) begin
          state_d = END;
          done_d  = 1'b1;
          pass_d  = !error_q;
        end else begin
          state_d = WRITE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (active) fvec_d = fvec_q | (bus.chk_fail & mask_q);
    // Applied lowest priority first so fail > timeout > stop > finish.
    if (stop_hit) begin
      state_d = IDLE;
      pass_d  = 1'b0;
      done_d  = 1'b1;
    end
    if (timeout) begin
      state_d = ERR;
      error_d = 1'b1;
      tmo_d   = 1'b1;
      pass_d  = 1'b0;
      done_d  = 1'b1;
    end
    if (fail_hit) begin
      state_d = ERR;
      error_d = 1'b1;
      tmo_d   = tmo_q;
      pass_d  = 1'b0;
      done_d  = 1'b1;
    end
    en_d = (state_d == WRITE || state_d == READ) ? NUM_CHK'(1) << idx_d : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      lc_q    <= '0;
      loops_q <= '0;
      pass_q  <= 1'b0;
      error_q <= 1'b0;
      tmo_q   <= 1'b0;
      fvec_q  <= '0;
      done_q  <= 1'b0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      lc_q    <= lc_d;
      loops_q <= loops_d;
      pass_q  <= pass_d;
      error_q <= error_d;
      tmo_q   <= tmo_d;
      fvec_q  <= fvec_d;
      done_q  <= done_d;
      en_q    <= en_d;
    end
  assign bus.chk_wr_en   = en_q;
  assign bus.chk_rd_en   = en_q;
  assign bus.busy        = state_q != IDLE;
  assign bus.seq_done    = done_q;
  assign bus.pass        = pass_q;
  assign bus.error       = error_q;
  assign bus.timeout_err = tmo_q;
  assign bus.fail_vec    = fvec_q;
  assign bus.active_idx  = idx_q;
  assign bus.loops_done  = loops_q;
endmodule

// File: tb/tb_axi_checker_sequencer.sv
// tb_axi_checker_sequencer: directed campaigns against a queue model of the expected enable order.
module tb_axi_checker_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  axi_checker_sequencer_if #(.NUM_CHK(4), .LOOP_W(16)) bus ();
  axi_checker_sequencer #(.NUM_CHK(4), .LOOP_W(16), .TIMEOUT_CYC(64)) dut (.clk(clk), .rst(rst), .bus(bus));
  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int exp_pop = 1;
  int camp_id = 0;
  bit mon_on = 1'b0;
  int rsp_lat = 5;
  bit rsp_hang = 1'b0;
  int rsp_ph = 0;
  int rsp_cnt = 0;
  int rsp_idx = 0;
  int seg = 0;
  int cur = 0;
  int gap = 0;
  int gap_max = 0;
  int mon_id = 0;
  logic [31:0] obs = '0;
  logic [3:0] prev_en = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic int idx_of(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction
  // Model: the n-th enable window of a campaign must belong to exp_q[n], and loops_done at its
  // start must equal the number of whole passes over the mask already completed.
  always @(negedge clk) begin
    if (mon_id != camp_id) begin
      mon_id = camp_id;
      seg = 0;
      gap = 0;
      gap_max = 0;
      obs = '0;
      prev_en = '0;
    end
    if (mon_on) begin
      if (bus.chk_wr_en != 0 && prev_en == 0) begin
        cur = seg < exp_q.size() ? exp_q[seg] : 15;
        chk("loops_done_at_window", 32'(bus.loops_done), seg / exp_pop);
        if (seg > 0 && gap > gap_max) gap_max = gap;
        obs = {obs[27:0], 4'(bus.active_idx)};
        seg++;
        gap = 0;
      end
      if (bus.chk_wr_en != 0) begin
        chk("wr_en", 32'(bus.chk_wr_en), 32'(1) << cur);
        chk("rd_en", 32'(bus.chk_rd_en), 32'(1) << cur);
        chk("active_idx", 32'(bus.active_idx), cur);
        chk("busy_while_enabled", 32'(bus.busy), 1);
      end else if (bus.busy) gap++;
      prev_en = bus.chk_wr_en;
    end
  end
  // Checker model: finish each phase rsp_lat cycles after the enable appears (write never finishes when hung).
  initial begin
    bus.chk_wr_finish = '0;
    bus.chk_rd_finish = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.chk_wr_finish = '0;
      bus.chk_rd_finish = '0;
      if (rsp_ph == 0 && bus.chk_wr_en != 0) begin
        rsp_idx = idx_of(bus.chk_wr_en);
        rsp_ph = 1;
        rsp_cnt = 0;
      end else if (rsp_ph != 0 && bus.chk_wr_en == 0) begin
        rsp_ph = 0;
      end else if (rsp_ph == 1 || rsp_ph == 2) begin
        rsp_cnt++;
        if (rsp_cnt == rsp_lat && !(rsp_ph == 1 && rsp_hang)) begin
          if (rsp_ph == 1) bus.chk_wr_finish[rsp_idx] = 1'b1;
          else bus.chk_rd_finish[rsp_idx] = 1'b1;
          rsp_ph++;
          rsp_cnt = 0;
        end
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic launch(input logic [3:0] m, input logic [15:0] lc, input int lat);
    exp_q.delete();
    exp_pop = $countones(m) == 0 ? 1 : $countones(m);
    for (int l = 0; l < (lc == 0 ? 8 : int'(lc)); l++)
      for (int i = 0; i < 4; i++) if (m[i]) exp_q.push_back(i);
    rsp_lat = lat;
    camp_id++;
    bus.chk_mask = m;
    bus.loop_count = lc;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask
  task automatic wait_done(input int maxc, input bit tog);
    int n = 0;
    while (!bus.seq_done && n < maxc) begin
      if (tog) bus.chk_fail[1] = ~bus.chk_fail[1];
      step();
      n++;
    end
    chk("seq_done_in_time", 32'(n < maxc), 1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1);
  end
  initial begin
    int n;
    bit seen_b;
    int nsd;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.loop_count = '0;
    bus.chk_mask = '0;
    bus.chk_fail = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_seq_done", 32'(bus.seq_done), 0);
    chk("rst_pass", 32'(bus.pass), 0);
    chk("rst_error", 32'(bus.error), 0);
    chk("rst_timeout", 32'(bus.timeout_err), 0);
    chk("rst_fail_vec", 32'(bus.fail_vec), 0);
    chk("rst_active_idx", 32'(bus.active_idx), 0);
    chk("rst_loops", 32'(bus.loops_done), 0);
    chk("rst_wr_en", 32'(bus.chk_wr_en), 0);
    mon_on = 1'b1;
    launch(4'b0101, 16'd2, 20);
    chk("t1_busy_after_start", 32'(bus.busy), 1);
    chk("t1_wr_en_after_start", 32'(bus.chk_wr_en), 32'h1);
    wait_done(1000, 1'b0);
    chk("t1_pass", 32'(bus.pass), 1);
    chk("t1_error", 32'(bus.error), 0);
    chk("t1_loops", 32'(bus.loops_done), 2);
    chk("t1_order", obs, 32'h0202);
    chk("t1_windows", seg, 4);
    chk("t1_idle_gap", gap_max, 1);
    step();
    chk("t1_done_one_cycle", 32'(bus.seq_done), 0);
    chk("t1_busy_end", 32'(bus.busy), 0);
    launch(4'b1000, 16'd3, 5);
    wait_done(500, 1'b0);
    chk("t2_pass", 32'(bus.pass), 1);
    chk("t2_loops", 32'(bus.loops_done), 3);
    chk("t2_order", obs, 32'h333);
    chk("t2_windows", seg, 3);
    step();
    launch(4'b0110, 16'd1, 10);
    n = 0;
    while (!(bus.chk_wr_en[2] && rsp_ph == 2 && rsp_cnt == 3) && n < 500) begin
      step();
      n++;
    end
    chk("t3_reach_read2", 32'(n < 500), 1);
    bus.chk_fail = 4'b0100;
    step();
    chk("t3_wr_en_off", 32'(bus.chk_wr_en), 0);
    chk("t3_rd_en_off", 32'(bus.chk_rd_en), 0);
    chk("t3_error", 32'(bus.error), 1);
    chk("t3_seq_done", 32'(bus.seq_done), 1);
    chk("t3_fail_vec", 32'(bus.fail_vec), 32'h4);
    chk("t3_pass", 32'(bus.pass), 0);
    chk("t3_timeout", 32'(bus.timeout_err), 0);
    bus.chk_fail = '0;
    step();
    chk("t3_idle", 32'(bus.busy), 0);
    chk("t3_error_sticky", 32'(bus.error), 1);
    mon_on = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("arst_error", 32'(bus.error), 0);
    chk("arst_fail_vec", 32'(bus.fail_vec), 0);
    step();
    rst = 1'b0;
    step();
    mon_on = 1'b1;
    launch(4'b0000, 16'd1, 5);
    seen_b = 1'b0;
    nsd = 0;
    repeat (6) begin
      seen_b |= bus.busy;
      nsd += int'(bus.seq_done);
      step();
    end
    chk("t6_mask0_busy", 32'(seen_b), 0);
    chk("t6_mask0_done", nsd, 0);
    launch(4'b0001, 16'd2, 4);
    wait_done(500, 1'b1);
    bus.chk_fail = '0;
    chk("t7_error", 32'(bus.error), 0);
    chk("t7_pass", 32'(bus.pass), 1);
    chk("t7_fail_vec", 32'(bus.fail_vec), 0);
    chk("t7_loops", 32'(bus.loops_done), 2);
    step();
    rsp_hang = 1'b1;
    launch(4'b0001, 16'd1, 5);
`ifdef CHK_SEQ_WATCHDOG_EN
    repeat (63) step();
    chk("t4_no_timeout_63", 32'(bus.error), 0);
    step();
    chk("t4_error_64", 32'(bus.error), 1);
    chk("t4_timeout_64", 32'(bus.timeout_err), 1);
    chk("t4_seq_done_64", 32'(bus.seq_done), 1);
    chk("t4_en_off_64", 32'(bus.chk_wr_en), 0);
    step();
    chk("t4_idle", 32'(bus.busy), 0);
`else
    repeat (10000) step();
    chk("t4_hung_busy", 32'(bus.busy), 1);
    chk("t4_hung_wr_en", 32'(bus.chk_wr_en), 32'h1);
    chk("t4_hung_error", 32'(bus.error), 0);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("t4_stop_busy", 32'(bus.busy), 0);
    chk("t4_stop_done", 32'(bus.seq_done), 1);
    chk("t4_stop_en", 32'(bus.chk_wr_en), 0);
    chk("t4_stop_timeout", 32'(bus.timeout_err), 0);
`endif
    rsp_hang = 1'b0;
    step();
    launch(4'b1111, 16'd0, 3);
    n = 0;
    while (bus.loops_done != 16'd5 && n < 2000) begin
      step();
      n++;
    end
    chk("t5_reach_5_loops", 32'(n < 2000), 1);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("t5_busy", 32'(bus.busy), 0);
    chk("t5_seq_done", 32'(bus.seq_done), 1);
    chk("t5_pass", 32'(bus.pass), 0);
    chk("t5_error", 32'(bus.error), 0);
    chk("t5_loops", 32'(bus.loops_done), 5);
    chk("t5_en", 32'(bus.chk_wr_en), 0);
    step();
    chk("t5_done_one_cycle", 32'(bus.seq_done), 0);
    launch(4'b0011, 16'd0, 3);
    repeat (15) step();
    chk("t8_busy_before_rst", 32'(bus.busy), 1);
    mon_on = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("t8_busy", 32'(bus.busy), 0);
    chk("t8_wr_en", 32'(bus.chk_wr_en), 0);
    chk("t8_rd_en", 32'(bus.chk_rd_en), 0);
    chk("t8_loops", 32'(bus.loops_done), 0);
    chk("t8_active_idx", 32'(bus.active_idx), 0);
    step();
    rst = 1'b0;
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
